draw_board_bg: RTL and testbench



---
 rtl/draw_board_bg_if.sv | 14 +
 rtl/draw_board_bg.sv | 238 +++++++++++++++++++++++
 tb/tb_draw_board_bg.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/draw_board_bg_if.sv
// VGA timing + colour bundle passed between draw-chain stages.
// master drives the fields, slave samples them.
interface draw_board_bg_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_board_bg.sv
// Background, screen-edge markers, N_BOARDS chessboards with frames, 2-cycle pipeline.
// Optional blinking square highlight enabled by defining DRAW_BOARD_BG_HIGHLIGHT_EN.
module draw_board_bg #(
  parameter int unsigned N_BOARDS     = 2,
  parameter int unsigned BOARD_X0     = 83,
  parameter int unsigned BOARD_PITCH  = 457,
  parameter int unsigned BOARD_Y0     = 180,
  parameter int unsigned SQ_SIZE      = 45,
  parameter int unsigned N_SQ         = 9,
  parameter int unsigned FRAME_W      = 3,
  parameter logic [11:0] LIGHT_COLOR  = 12'h888,
  parameter logic [11:0] DARK_COLOR   = 12'h988,
  parameter logic [11:0] FRAME_COLOR  = 12'h321,
  parameter logic [11:0] BG_COLOR     = 12'hFAC,
  parameter logic [11:0] HL_COLOR     = 12'h0FF,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter int unsigned HOR_PIXELS   = 1024,
  parameter int unsigned VER_PIXELS   = 768
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            sel_valid_i,
  input  logic [1:0]      sel_board_i,
  input  logic [3:0]      sel_col_i,
  input  logic [3:0]      sel_row_i,
  draw_board_bg_if.slave  vga_in_i,
  draw_board_bg_if.master vga_out_o
);

  localparam int BoardLen = int'(N_SQ * SQ_SIZE);
  localparam int XOrg     = int'(BOARD_X0);
  localparam int Pitch    = int'(BOARD_PITCH);
  localparam int YOrg     = int'(BOARD_Y0);
  localparam int Fw       = int'(FRAME_W);
  localparam int PixW     = $clog2(SQ_SIZE);
  localparam logic [PixW-1:0] PixLast = PixW'(SQ_SIZE - 1);
  localparam logic [3:0]      SqLast  = 4'(N_SQ - 1);

  if (N_BOARDS > 1 && BOARD_PITCH < N_SQ * SQ_SIZE + 2 * FRAME_W) begin : g_overlap_err
    $error("draw_board_bg: BOARD_PITCH too small, boards and frames overlap");
  end

  // Stage 1 registers
  logic [10:0]     vcount1_q, hcount1_q;
  logic            vsync1_q, vblnk1_q, hsync1_q, hblnk1_q;
  logic            in_h_q, in_h_d, in_v_q, in_v_d;
  logic [1:0]      board_q, board_d;
  logic [PixW-1:0] hpix_q, hpix_d, vpix_q, vpix_d;
  logic [3:0]      col_q, col_d, row_q, row_d;
  logic            frame_q, frame_d;
  logic            hit_q, hit_d;

  // Stage 2 registers
  logic [10:0]     vcount2_q, hcount2_q;
  logic            vsync2_q, vblnk2_q, hsync2_q, hblnk2_q;
  logic [11:0]     rgb_q, rgb_d;

  int              h_int, v_int;
  logic            is_origin, frame_h, area_h, frame_v, area_v;
  logic [1:0]      origin_idx;

  always_comb begin
    h_int      = int'(vga_in_i.hcount);
    v_int      = int'(vga_in_i.vcount);
    is_origin  = 1'b0;
    origin_idx = 2'd0;
    frame_h    = 1'b0;
    area_h     = 1'b0;
    for (int b = 0; b < int'(N_BOARDS); b++) begin
      if (h_int == XOrg + b * Pitch) begin
        is_origin  = 1'b1;
        origin_idx = 2'(b);
      end
      if (h_int >= XOrg + b * Pitch - Fw && h_int < XOrg + b * Pitch + BoardLen + Fw) begin
        frame_h = 1'b1;
      end
      if (h_int >= XOrg + b * Pitch && h_int < XOrg + b * Pitch + BoardLen) begin
        area_h = 1'b1;
      end
    end
    frame_v = (v_int >= YOrg - Fw) && (v_int < YOrg + BoardLen + Fw);
    area_v  = (v_int >= YOrg) && (v_int < YOrg + BoardLen);
    frame_d = frame_h & frame_v & ~(area_h & area_v);
  end

  // Square position tracking by counters: no divide in the pixel path.
  always_comb begin
    in_h_d  = in_h_q;
    board_d = board_q;
    hpix_d  = hpix_q;
    col_d   = col_q;
    if (is_origin) begin
      in_h_d  = 1'b1;
      board_d = origin_idx;
      hpix_d  = '0;
      col_d   = 4'd0;
    end else if (in_h_q) begin
      if (hpix_q == PixLast) begin
        hpix_d = '0;
        col_d  = col_q + 4'd1;
        if (col_q == SqLast) in_h_d = 1'b0;
      end else begin
        hpix_d = hpix_q + 1'b1;
      end
    end

    in_v_d = in_v_q;
    vpix_d = vpix_q;
    row_d  = row_q;
    if (vga_in_i.hcount == 11'd0) begin
      if (v_int == YOrg) begin
        in_v_d = 1'b1;
        vpix_d = '0;
        row_d  = 4'd0;
      end else if (in_v_q) begin
        if (vpix_q == PixLast) begin
          vpix_d = '0;
          row_d  = row_q + 4'd1;
          if (row_q == SqLast) in_v_d = 1'b0;
        end else begin
          vpix_d = vpix_q + 1'b1;
        end
      end
    end
  end

`ifdef DRAW_BOARD_BG_HIGHLIGHT_EN
  localparam int BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_on_q;
  logic              vsync_rise;
  logic              unused_in;

  assign vsync_rise = vga_in_i.vsync & ~vsync1_q;
  assign unused_in  = ^vga_in_i.rgb;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (vsync_rise) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_q <= '0;
        blink_on_q  <= ~blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign hit_d = sel_valid_i & blink_on_q & in_h_d & in_v_d & (board_d == sel_board_i) &
                 (col_d == sel_col_i) & (row_d == sel_row_i);
`else
  logic unused_in;
  assign unused_in = ^{vga_in_i.rgb, sel_valid_i, sel_board_i, sel_col_i, sel_row_i};
  assign hit_d     = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vcount1_q <= '0;
      hcount1_q <= '0;
      vsync1_q  <= 1'b0;
      vblnk1_q  <= 1'b0;
      hsync1_q  <= 1'b0;
      hblnk1_q  <= 1'b0;
      in_h_q    <= 1'b0;
      in_v_q    <= 1'b0;
      board_q   <= '0;
      hpix_q    <= '0;
      vpix_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      frame_q   <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      vcount1_q <= vga_in_i.vcount;
      hcount1_q <= vga_in_i.hcount;
      vsync1_q  <= vga_in_i.vsync;
      vblnk1_q  <= vga_in_i.vblnk;
      hsync1_q  <= vga_in_i.hsync;
      hblnk1_q  <= vga_in_i.hblnk;
      in_h_q    <= in_h_d;
      in_v_q    <= in_v_d;
      board_q   <= board_d;
      hpix_q    <= hpix_d;
      vpix_q    <= vpix_d;
      col_q     <= col_d;
      row_q     <= row_d;
      frame_q   <= frame_d;
      hit_q     <= hit_d;
    end
  end

  always_comb begin
    rgb_d = BG_COLOR;
    if (vblnk1_q | hblnk1_q)                        rgb_d = 12'h000;
    else if (vcount1_q == 11'd0)                    rgb_d = 12'hFF0;
    else if (vcount1_q == 11'(VER_PIXELS - 1))      rgb_d = 12'hF00;
    else if (hcount1_q == 11'd0)                    rgb_d = 12'h0F0;
    else if (hcount1_q == 11'(HOR_PIXELS - 1))      rgb_d = 12'h00F;
    else if (hit_q)                                 rgb_d = HL_COLOR;
    else if (in_h_q & in_v_q)                       rgb_d = (col_q[0] ^ row_q[0]) ? DARK_COLOR
                                                                                   : LIGHT_COLOR;
    else if (frame_q)                               rgb_d = FRAME_COLOR;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vcount2_q <= '0;
      hcount2_q <= '0;
      vsync2_q  <= 1'b0;
      vblnk2_q  <= 1'b0;
      hsync2_q  <= 1'b0;
      hblnk2_q  <= 1'b0;
      rgb_q     <= '0;
    end else begin
      vcount2_q <= vcount1_q;
      hcount2_q <= hcount1_q;
      vsync2_q  <= vsync1_q;
      vblnk2_q  <= vblnk1_q;
      hsync2_q  <= hsync1_q;
      hblnk2_q  <= hblnk1_q;
      rgb_q     <= rgb_d;
    end
  end

  assign vga_out_o.vcount = vcount2_q;
  assign vga_out_o.vsync  = vsync2_q;
  assign vga_out_o.vblnk  = vblnk2_q;
  assign vga_out_o.hcount = hcount2_q;
  assign vga_out_o.hsync  = hsync2_q;
  assign vga_out_o.hblnk  = hblnk2_q;
  assign vga_out_o.rgb    = rgb_q;

endmodule

// File: tb/tb_draw_board_bg.sv
// Bench for draw_board_bg: geometric reference model checked every cycle, plus literal pixels.
// Highlight expectations follow DRAW_BOARD_BG_HIGHLIGHT_EN.
module tb_draw_board_bg;
  localparam int NB = 2, X0 = 83, P = 457, Y0 = 180, SQ = 45, NSQ = 9, FW = 3, BL = 2;
  localparam int LEN = NSQ * SQ;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_valid;
  logic [1:0] sel_board;
  logic [3:0] sel_col, sel_row;

  always #5 clk = ~clk;

  draw_board_bg_if vin ();
  draw_board_bg_if vout ();

  draw_board_bg #(.BLINK_FRAMES(BL)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sel_valid_i (sel_valid),
    .sel_board_i (sel_board),
    .sel_col_i   (sel_col),
    .sel_row_i   (sel_row),
    .vga_in_i    (vin),
    .vga_out_o   (vout)
  );

  typedef struct {
    bit          valid;
    logic [37:0] f;
    bit          lit_en;
    logic [11:0] lit;
    int          id;
  } exp_t;

  exp_t cur, p1, p2;
  int   errors = 0, checks = 0;

  // Reference model state
  int board_seen, rises;
  bit armed_v, prev_vs;

  int          lh[13] = '{83, 128, 540, 487, 80, 488, 491, 500, 500, 0, 1050, 1023, 500};
  int          lv[13] = '{180, 180, 225, 584, 177, 300, 300, 100, 0, 300, 300, 300, 767};
  logic [11:0] lc[13] = '{12'h888, 12'h988, 12'h988, 12'h888, 12'h321, 12'h321, 12'hFAC,
                          12'hFAC, 12'hFF0, 12'h0F0, 12'h000, 12'h00F, 12'hF00};
`ifdef DRAW_BOARD_BG_HIGHLIGHT_EN
  logic [11:0] blink_exp[8] = '{12'h0FF, 12'h0FF, 12'h988, 12'h988, 12'h0FF, 12'h988,
                                12'hFAC, 12'h988};
`else
  logic [11:0] blink_exp[8] = '{12'h988, 12'h988, 12'h988, 12'h988, 12'h988, 12'h988,
                                12'hFAC, 12'h988};
`endif

  function automatic logic [11:0] model_rgb(int h, int v, bit hb, bit vb);
    bit on_board = 0, hit = 0, in_frame = 0, in_area = 0;
    int col = 0, row = 0;
    for (int b = 0; b < NB; b++) begin
      int o = X0 + b * P;
      bit ha = (h >= o) && (h < o + LEN);
      bit va = (v >= Y0) && (v < Y0 + LEN);
      if (h >= o - FW && h < o + LEN + FW && v >= Y0 - FW && v < Y0 + LEN + FW) in_frame = 1;
      if (ha && va) in_area = 1;
      if (board_seen == b && armed_v && ha && va) begin
        on_board = 1;
        col = (h - o) / SQ;
        row = (v - Y0) / SQ;
`ifdef DRAW_BOARD_BG_HIGHLIGHT_EN
        hit = sel_valid && ((rises / BL) % 2 == 0) && int'(sel_board) == b &&
              int'(sel_col) == col && int'(sel_row) == row;
`endif
      end
    end
    if (hb || vb)           return 12'h000;
    if (v == 0)             return 12'hFF0;
    if (v == 767)           return 12'hF00;
    if (h == 0)             return 12'h0F0;
    if (h == 1023)          return 12'h00F;
    if (hit)                return 12'h0FF;
    if (on_board)           return ((col + row) % 2 == 0) ? 12'h888 : 12'h988;
    if (in_frame && !in_area) return 12'h321;
    return 12'hFAC;
  endfunction

  task automatic get_lit(int fr, int h, int v, output bit en, output logic [11:0] val,
                         output int id);
    en = 0; val = '0; id = 0;
    if (h == 630 && v == 315) begin
      en = 1; val = blink_exp[fr]; id = 1;
    end else if (fr == 6 && v > 300) begin
      if ((h == 83 && v == 315) || (h == 487 && v == 584)) begin
        en = 1; val = 12'hFAC; id = 2;
      end
    end else if (fr == 0 || fr == 6 || fr == 7) begin
      for (int i = 0; i < 13; i++)
        if (h == lh[i] && v == lv[i]) begin
          en = 1; val = lc[i]; id = 3 + i;
        end
    end
  endtask

  task automatic pix(int h, int v, bit r, bit len, logic [11:0] lval, int lid);
    bit hb = (h >= 1024), vb = (v >= 768);
    bit hs = (h >= 1048 && h < 1184), vs = (v >= 771 && v < 777);
    vin.hcount = 11'(h); vin.vcount = 11'(v);
    vin.hblnk = hb; vin.vblnk = vb; vin.hsync = hs; vin.vsync = vs;
    vin.rgb = 12'($urandom);
    rst = r;
    if (r) begin
      board_seen = -1; armed_v = 0; prev_vs = 0; rises = 0;
      cur.valid = 0;
    end else begin
      if (h == 0 && v == Y0) armed_v = 1;
      for (int b = 0; b < NB; b++) if (h == X0 + b * P) board_seen = b;
      cur.valid  = 1;
      cur.f      = {11'(v), vs, vb, 11'(h), hs, hb, model_rgb(h, v, hb, vb)};
      cur.lit_en = len; cur.lit = lval; cur.id = lid;
      if (vs && !prev_vs) rises++;
      prev_vs = vs;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit full_line(int v);
    return v == 0 || v == 100 || v == 177 || v == 180 || v == 225 || v == 300 || v == 315 ||
           v == 584 || v == 767;
  endfunction

  task automatic frame(int fr, bit full, int rst_v);
    bit en; logic [11:0] val; int id;
    for (int v = 0; v < 806; v++) begin
      pix(0, v, 0, 0, '0, 0);
      if (full ? full_line(v) : (v == 315)) begin
        for (int h = 1; h <= (full ? 1100 : 1000); h++) begin
          get_lit(fr, h, v, en, val, id);
          pix(h, v, (v == rst_v && h == 200), en, val, id);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      p1.valid <= 0;
      p2       <= '{valid: 1, f: '0, lit_en: 0, lit: '0, id: 0};
    end else begin
      p1 <= cur;
      p2 <= p1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (p2.valid) begin
      logic [37:0] act;
      act = {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk, vout.rgb};
      checks++;
      if (act[37:12] !== p2.f[37:12]) begin
        errors++;
        $display("FAIL timing at t=%0t: got %h required %h", $time, act[37:12], p2.f[37:12]);
      end
      checks++;
      if (act[11:0] !== p2.f[11:0]) begin
        errors++;
        $display("FAIL rgb_model at h=%0d v=%0d: got %h required %h",
                 p2.f[24:14], p2.f[37:27], act[11:0], p2.f[11:0]);
      end
      if (p2.lit_en) begin
        checks++;
        if (act[11:0] !== p2.lit) begin
          errors++;
          $display("FAIL rgb_literal id=%0d at h=%0d v=%0d: got %h required %h",
                   p2.id, p2.f[24:14], p2.f[37:27], act[11:0], p2.lit);
        end
      end
    end
  end

  initial begin
    sel_valid = 1; sel_board = 2'd1; sel_col = 4'd2; sel_row = 4'd3;
    cur.valid = 0;
    repeat (3) pix(5, 300, 1, 0, '0, 0);
    frame(0, 1, -1);
    for (int fr = 1; fr <= 4; fr++) frame(fr, 0, -1);
    sel_board = 2'd3;
    frame(5, 0, -1);
    frame(6, 1, 300);
    frame(7, 1, -1);
    cur.valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
